// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter with RAM/GPIO address decode and the GPIO output register.
// Latency: issue is combinational in the grant cycle, and read data returns one cycle later.
// Backpressure: a loser keeps its request held until granted; optional m1 bus lock via `DBUS_LOCK_EN`.
module dbus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int GPIO_W      = 8,
    parameter int RAM_REGION  = 0,
    parameter int GPIO_REGION = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rd,
    input  logic [3:0]        m0_wr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rd,
    input  logic [3:0]        m1_wr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
`ifdef DBUS_LOCK_EN
    input  logic              m1_lock,
`endif
    output logic              s_en,
    output logic [ADDR_W-1:0] s_addr,
    output logic [3:0]        s_wr,
    output logic [31:0]       s_wdata,
    input  logic [31:0]       s_rdata,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              err
);

    localparam int TAG_W = ADDR_W - 10;
    localparam logic [TAG_W-1:0] RAM_TAG  = TAG_W'(RAM_REGION);
    localparam logic [TAG_W-1:0] GPIO_TAG = TAG_W'(GPIO_REGION);

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_GPIO = 2'd2
    } src_t;

    logic              last_gnt;
    logic              lock;
    logic              any_gnt;
    logic [ADDR_W-1:0] win_addr;
    logic              win_rd;
    logic [3:0]        win_wr;
    logic [31:0]       win_wdata;
    logic [TAG_W-1:0]  win_tag;
    logic              is_ram;
    logic              is_gpio;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [GPIO_W-1:0] gpio_q;
    logic              rsp_valid;
    logic              rsp_owner;
    src_t              rsp_src;
    logic [GPIO_W-1:0] rsp_gpio;
    logic [31:0]       rsp_data;
    logic              err_q;

    // m0 wins when alone, or on a tie when m1 had the previous grant; lock shuts m0 out entirely.
    assign m0_gnt  = ~rst & m0_req & ~lock & (~m1_req | last_gnt);
    assign m1_gnt  = ~rst & m1_req & ~m0_gnt;
    assign any_gnt = m0_gnt | m1_gnt;

    // Forward the winner's transfer fields.
    always_comb begin
        win_addr  = m0_addr;
        win_rd    = m0_rd;
        win_wr    = m0_wr;
        win_wdata = m0_wdata;
        if (m1_gnt) begin
            win_addr  = m1_addr;
            win_rd    = m1_rd;
            win_wr    = m1_wr;
            win_wdata = m1_wdata;
        end
    end

    assign win_tag = win_addr[ADDR_W-1:10];
    assign is_ram  = (win_tag == RAM_TAG);
    assign is_gpio = (win_tag == GPIO_TAG);

    // RAM is strobed only for a granted RAM-region access; address/data hold when idle.
    assign s_en    = any_gnt & is_ram;
    assign s_wr    = s_en ? win_wr : 4'b0000;
    assign s_addr  = any_gnt ? win_addr : addr_q;
    assign s_wdata = any_gnt ? win_wdata : wdata_q;
    assign gpio_o  = gpio_q;
    assign err     = err_q;

    // Round-robin history: remember which master took the most recent grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (any_gnt) begin
            last_gnt <= m1_gnt;
        end
    end

`ifdef DBUS_LOCK_EN
    // Lock follows m1_lock on each m1 grant; it survives m1 dropping its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock <= 1'b0;
        end else if (m1_gnt) begin
            lock <= m1_lock;
        end
    end
`else
    assign lock = 1'b0;
`endif

    // Hold the last issued slave address and write data across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_gnt) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
        end
    end

    // The GPIO register takes lane 0 only; writes touching other lanes alone are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q <= '0;
        end else if (any_gnt && is_gpio && win_wr[0]) begin
            gpio_q <= win_wdata[GPIO_W-1:0];
        end
    end

    // Read-return pipeline: capture the owner, the data source, and the pre-write GPIO value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_src   <= SRC_ZERO;
            rsp_gpio  <= '0;
        end else begin
            rsp_valid <= any_gnt & win_rd;
            if (any_gnt && win_rd) begin
                rsp_owner <= m1_gnt;
                rsp_gpio  <= gpio_q;
                if (is_ram) begin
                    rsp_src <= SRC_RAM;
                end else if (is_gpio) begin
                    rsp_src <= SRC_GPIO;
                end else begin
                    rsp_src <= SRC_ZERO;
                end
            end
        end
    end

    // An unmapped access pulses err in the cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= any_gnt & ~is_ram & ~is_gpio;
        end
    end

    // Select the returning data by source.
    always_comb begin
        rsp_data = 32'h0;
        case (rsp_src)
            SRC_RAM:  rsp_data = s_rdata;
            SRC_GPIO: rsp_data = 32'(rsp_gpio);
            default:  rsp_data = 32'h0;
        endcase
    end

    assign m0_rvalid = rsp_valid & ~rsp_owner;
    assign m1_rvalid = rsp_valid & rsp_owner;
    assign m0_rdata  = m0_rvalid ? rsp_data : 32'h0;
    assign m1_rdata  = m1_rvalid ? rsp_data : 32'h0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: vector table of bus cycles, plus a mid-transfer reset sequence.
// Read responses are predicted by a reference model and queued for the following cycle.
// A behavioural synchronous RAM sits on the slave port.
module tb_dbus_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_rd, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wr;
    logic        m1_req, m1_rd, m1_gnt, m1_rvalid, m1_lock;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wr;
    logic        s_en;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wr;
    logic [7:0]  gpio_o;
    logic        err;

    dbus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DBUS_LOCK_EN
        .m1_lock(m1_lock),
`endif
        .s_en(s_en), .s_addr(s_addr), .s_wr(s_wr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .gpio_o(gpio_o), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hD000_0000 | (32'(i) * 32'h0000_0101);
    endfunction

    // Synchronous-read RAM, reloaded with a known pattern while in reset.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (s_en) begin
            s_rdata <= mem[s_addr[9:2]];
            for (int l = 0; l < 4; l++)
                if (s_wr[l]) mem[s_addr[9:2]][8*l +: 8] <= s_wdata[8*l +: 8];
        end
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        rd;
        logic [3:0]  wr;
        logic [31:0] wd;
    } mreq_t;

    typedef struct {
        mreq_t      m0;
        mreq_t      m1;
        logic       lk;
        logic       g0;
        logic       g1;
        logic       sen;
    } vec_t;

    typedef struct {
        logic        rd;
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    function automatic mreq_t IDLE();
        return '{req: 1'b0, addr: 32'h0, rd: 1'b0, wr: 4'h0, wd: 32'h0};
    endfunction
    function automatic mreq_t R(input logic [31:0] a);
        return '{req: 1'b1, addr: a, rd: 1'b1, wr: 4'h0, wd: 32'h0};
    endfunction
    function automatic mreq_t W(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        return '{req: 1'b1, addr: a, rd: 1'b0, wr: w, wd: d};
    endfunction
    function automatic mreq_t RW(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        return '{req: 1'b1, addr: a, rd: 1'b1, wr: w, wd: d};
    endfunction
    function automatic mreq_t NOP(input logic [31:0] a);
        return '{req: 1'b1, addr: a, rd: 1'b0, wr: 4'h0, wd: 32'h0};
    endfunction
    // exp = {m0_gnt, m1_gnt, s_en}
    function automatic vec_t V(input mreq_t a, input mreq_t b, input logic lk, input logic [2:0] exp);
        return '{m0: a, m1: b, lk: lk, g0: exp[2], g1: exp[1], sen: exp[0]};
    endfunction

    int          n_pass = 0;
    int          n_total = 0;
    exp_t        exp_q[$];
    logic [31:0] ref_ram [0:255];
    logic [7:0]  ref_gpio;
    logic [31:0] last_addr, last_wd;
    vec_t        tv[$];
    vec_t        lv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ref_ram[i] = init_word(i);
        ref_gpio  = 8'h00;
        last_addr = 32'h0;
        last_wd   = 32'h0;
        exp_q.delete();
    endtask

    task automatic drive(input vec_t v);
        m0_req = v.m0.req; m0_addr = v.m0.addr; m0_rd = v.m0.rd; m0_wr = v.m0.wr; m0_wdata = v.m0.wd;
        m1_req = v.m1.req; m1_addr = v.m1.addr; m1_rd = v.m1.rd; m1_wr = v.m1.wr; m1_wdata = v.m1.wd;
        m1_lock = v.lk;
    endtask

    // Compare the response due this cycle (from the previous issue).
    task automatic check_rsp();
        exp_t e;
        e = '{rd: 1'b0, owner: 1'b0, data: 32'h0, err: 1'b0};
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e.rd && !e.owner));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e.rd && e.owner));
        chk("m0_rdata", m0_rdata, (e.rd && !e.owner) ? e.data : 32'h0);
        chk("m1_rdata", m1_rdata, (e.rd && e.owner) ? e.data : 32'h0);
        chk("err", 32'(err), 32'(e.err));
    endtask

    // Called at posedge+1: drive one cycle, check at negedge, update model, return at posedge+1.
    task automatic apply(input vec_t v);
        mreq_t       w;
        logic        g, ram, gp;
        exp_t        e;
        drive(v);
        @(negedge clk);
        check_rsp();
        g   = v.g0 | v.g1;
        w   = v.g1 ? v.m1 : v.m0;
        ram = (w.addr[31:10] == 22'd0);
        gp  = (w.addr[31:10] == 22'd1);
        chk("m0_gnt", 32'(m0_gnt), 32'(v.g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(v.g1));
        chk("both_gnt", 32'(m0_gnt & m1_gnt), 32'h0);
        chk("s_en", 32'(s_en), 32'(v.sen));
        chk("s_wr", 32'(s_wr), (g && ram) ? 32'(w.wr) : 32'h0);
        chk("s_addr", s_addr, g ? w.addr : last_addr);
        chk("s_wdata", s_wdata, g ? w.wd : last_wd);
        chk("gpio_o", 32'(gpio_o), 32'(ref_gpio));
        e.rd    = g & w.rd;
        e.owner = v.g1;
        e.err   = g & ~ram & ~gp;
        e.data  = ram ? ref_ram[w.addr[9:2]] : (gp ? 32'(ref_gpio) : 32'h0);
        exp_q.push_back(e);
        if (g) begin
            last_addr = w.addr;
            last_wd   = w.wd;
            if (ram)
                for (int l = 0; l < 4; l++)
                    if (w.wr[l]) ref_ram[w.addr[9:2]][8*l +: 8] = w.wd[8*l +: 8];
            if (gp && w.wr[0]) ref_gpio = w.wd[7:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_m0_gnt"}, 32'(m0_gnt), 32'h0);
        chk({tag, "_m1_gnt"}, 32'(m1_gnt), 32'h0);
        chk({tag, "_rvalid"}, 32'({m0_rvalid, m1_rvalid}), 32'h0);
        chk({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        chk({tag, "_m1_rdata"}, m1_rdata, 32'h0);
        chk({tag, "_s_en"}, 32'(s_en), 32'h0);
        chk({tag, "_s_wr"}, 32'(s_wr), 32'h0);
        chk({tag, "_s_addr"}, s_addr, 32'h0);
        chk({tag, "_s_wdata"}, s_wdata, 32'h0);
        chk({tag, "_gpio_o"}, 32'(gpio_o), 32'h0);
        chk({tag, "_err"}, 32'(err), 32'h0);
    endtask

    initial begin
        // Tie on reset: m0; then m1 holds its request.
        tv.push_back(V(R(32'h10), R(32'h20), 1'b0, 3'b101));
        tv.push_back(V(IDLE(), R(32'h20), 1'b0, 3'b011));
        tv.push_back(V(IDLE(), IDLE(), 1'b0, 3'b000));
        // Continuous contention alternates.
        tv.push_back(V(R(32'h40), R(32'h44), 1'b0, 3'b101));
        tv.push_back(V(R(32'h48), R(32'h4C), 1'b0, 3'b011));
        tv.push_back(V(R(32'h50), R(32'h54), 1'b0, 3'b101));
        tv.push_back(V(R(32'h58), R(32'h5C), 1'b0, 3'b011));
        tv.push_back(V(R(32'h60), R(32'h64), 1'b0, 3'b101));
        tv.push_back(V(R(32'h68), R(32'h6C), 1'b0, 3'b011));
        // GPIO write lane 0, read back.
        tv.push_back(V(W(32'h400, 4'b0001, 32'h0000_00A5), IDLE(), 1'b0, 3'b100));
        tv.push_back(V(R(32'h400), IDLE(), 1'b0, 3'b100));
        // GPIO write on lane 1 only is ignored; unmapped read.
        tv.push_back(V(W(32'h400, 4'b0010, 32'h0000_5A5A), IDLE(), 1'b0, 3'b100));
        tv.push_back(V(IDLE(), R(32'h800), 1'b0, 3'b010));
        tv.push_back(V(IDLE(), IDLE(), 1'b0, 3'b000));
        // RAM read+write returns pre-write data; byte-lane write.
        tv.push_back(V(IDLE(), RW(32'h30, 4'b1111, 32'h1234_5678), 1'b0, 3'b011));
        tv.push_back(V(IDLE(), R(32'h30), 1'b0, 3'b011));
        tv.push_back(V(RW(32'h34, 4'b0100, 32'h00AB_0000), IDLE(), 1'b0, 3'b101));
        tv.push_back(V(R(32'h34), IDLE(), 1'b0, 3'b101));
        // No-op grant still advances round-robin.
        tv.push_back(V(IDLE(), R(32'h08), 1'b0, 3'b011));
        tv.push_back(V(NOP(32'h00), IDLE(), 1'b0, 3'b101));
        tv.push_back(V(R(32'h0C), R(32'h1C), 1'b0, 3'b011));
        tv.push_back(V(R(32'h0C), IDLE(), 1'b0, 3'b101));
        tv.push_back(V(IDLE(), IDLE(), 1'b0, 3'b000));
        // GPIO read+write returns the pre-write value.
        tv.push_back(V(IDLE(), RW(32'h404, 4'b0001, 32'h0000_003C), 1'b0, 3'b010));
        tv.push_back(V(IDLE(), IDLE(), 1'b0, 3'b000));
        // Lock: m1 holds the bus while m0 waits, even after m1 drops its request.
        lv.push_back(V(IDLE(), R(32'h20), 1'b1, 3'b011));
        lv.push_back(V(R(32'h10), R(32'h24), 1'b1, 3'b011));
        lv.push_back(V(R(32'h10), R(32'h28), 1'b1, 3'b011));
        lv.push_back(V(R(32'h10), IDLE(), 1'b0, 3'b000));
        lv.push_back(V(R(32'h10), R(32'h2C), 1'b0, 3'b011));
        lv.push_back(V(R(32'h10), IDLE(), 1'b0, 3'b101));
        lv.push_back(V(IDLE(), IDLE(), 1'b0, 3'b000));

        rst = 1'b1;
        drive(V(R(32'h10), R(32'h20), 1'b0, 3'b000));
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("rst0");
        drive(V(IDLE(), IDLE(), 1'b0, 3'b000));
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tv[i]) apply(tv[i]);

        // Reset arrives the cycle after a RAM read is granted: the read is discarded.
        drive(V(R(32'h10), IDLE(), 1'b0, 3'b000));
        @(negedge clk);
        chk("pre_rst_m0_gnt", 32'(m0_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(V(R(32'h10), R(32'h20), 1'b0, 3'b000));
        #1;
        reset_checks("rst1");
        @(posedge clk);
        @(negedge clk);
        reset_checks("rst2");
        drive(V(IDLE(), IDLE(), 1'b0, 3'b000));
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply(V(R(32'h10), R(32'h20), 1'b0, 3'b101));
        apply(V(IDLE(), IDLE(), 1'b0, 3'b000));

`ifdef DBUS_LOCK_EN
        foreach (lv[i]) apply(lv[i]);
`endif
        apply(V(IDLE(), IDLE(), 1'b0, 3'b000));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
